// File: rtl/tm_input_ctrl_if.sv
// Symbol handshake between the input front end and the core.
// Master presents a show-ahead head symbol; slave accepts with ready.
interface tm_input_ctrl_if #(
    parameter int SYM_W = 4
);
    logic [SYM_W-1:0] sym_data;
    logic             sym_valid;
    logic             sym_ready;

    modport master (
        output sym_data,
        output sym_valid,
        input  sym_ready
    );

    modport slave (
        input  sym_data,
        input  sym_valid,
        output sym_ready
    );
endinterface

// File: rtl/tm_input_ctrl.sv
// Button/switch front end: sync, debounce, symbol FIFO and
// COLLECT/DRAIN/FINISH sequencing with an end-of-input strobe.
module tm_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DEPTH           = 8,
    parameter int SYM_W           = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [SYM_W-1:0]         sw_in,
    input  logic                     btn_next_raw,
    input  logic                     btn_done_raw,
    tm_input_ctrl_if.master          sym,
    output logic                     end_pulse,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow,
    output logic                     entry_open
);
    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 1;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT,
        DRAIN,
        FINISH
    } state_t;

    state_t state;
    state_t state_n;

    logic [1:0]            btn_s1;
    logic [1:0]            btn_s2;
    logic [1:0]            stable;
    logic [1:0]            stable_d;
    logic [1:0]            press;
    logic [1:0][CNT_W-1:0] cnt;
    logic [SYM_W-1:0]      sw_s1;
    logic [SYM_W-1:0]      sw_s2;

    logic [SYM_W-1:0]      mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [OCC_W-1:0]      count;

    logic next_press;
    logic done_press;
    logic full;
    logic pop;
    logic push_req;
    logic push;
    logic drop;
    logic drain_empty;

    // Bit 0 is Next, bit 1 is Done; each has its own counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            press    <= '0;
            cnt      <= '0;
        end else begin
            btn_s1   <= {btn_done_raw, btn_next_raw};
            btn_s2   <= btn_s1;
            sw_s1    <= sw_in;
            sw_s2    <= sw_s1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign next_press = press[0];
    assign done_press = press[1];

    assign full     = (count == OCC_W'(DEPTH));
    assign pop      = (count != '0) && sym.sym_ready;
    assign push_req = next_press && (state == COLLECT);
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sw_s2;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign sym.sym_data  = mem[rd_ptr];
    assign sym.sym_valid = (count != '0);
    assign occupancy     = count;

    // No pushes in DRAIN, so emptiness next cycle depends on pop only.
    assign drain_empty = (count == '0) ||
                         ((count == OCC_W'(1)) && pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            COLLECT: if (done_press)  state_n = DRAIN;
            DRAIN:   if (drain_empty) state_n = FINISH;
            FINISH:  state_n = COLLECT;
            default: state_n = COLLECT;
        endcase
    end

    always_comb begin
        end_pulse  = 1'b0;
        entry_open = 1'b0;
        unique case (1'b1)
            (state == COLLECT): entry_open = 1'b1;
            (state == FINISH):  end_pulse  = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_tm_input_ctrl.sv
// Directed bench for tm_input_ctrl with a short debounce window.
// Inputs are driven and outputs sampled on the falling edge.
module tb_tm_input_ctrl;
    localparam int DEB   = 4;
    localparam int DEPTH = 8;
    localparam int SYM_W = 4;

    logic             clock;
    logic             reset;
    logic [SYM_W-1:0] sw_in;
    logic             btn_next_raw;
    logic             btn_done_raw;
    logic             end_pulse;
    logic [3:0]       occupancy;
    logic             overflow;
    logic             entry_open;

    int checks;
    int errors;
    int seen_end;

    tm_input_ctrl_if #(.SYM_W(SYM_W)) sym_if ();

    tm_input_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .DEPTH          (DEPTH),
        .SYM_W          (SYM_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sw_in       (sw_in),
        .btn_next_raw(btn_next_raw),
        .btn_done_raw(btn_done_raw),
        .sym         (sym_if.master),
        .end_pulse   (end_pulse),
        .occupancy   (occupancy),
        .overflow    (overflow),
        .entry_open  (entry_open)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    // Clean Next press: pushes at cycle 8, release settles by 16.
    task automatic press_next(input logic [SYM_W-1:0] v);
        sw_in = v;
        step(3);
        btn_next_raw = 1'b1;
        step(8);
        btn_next_raw = 1'b0;
        step(8);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        seen_end         = 0;
        reset            = 1'b1;
        sw_in            = '0;
        btn_next_raw     = 1'b0;
        btn_done_raw     = 1'b0;
        sym_if.sym_ready = 1'b0;
        step(2);
        check("rst_occ", occupancy, 0);
        check("rst_valid", sym_if.sym_valid, 0);
        check("rst_data", sym_if.sym_data, 0);
        check("rst_end", end_pulse, 0);
        check("rst_ovf", overflow, 0);
        check("rst_open", entry_open, 1);
        reset = 1'b0;
        step(1);

        // Bouncing Next, then a clean hold
        sw_in = 4'hC;
        step(3);
        for (int i = 0; i < 5; i++) begin
            btn_next_raw = 1'b1;
            step(2);
            btn_next_raw = 1'b0;
            step(2);
        end
        check("bounce_occ", occupancy, 0);
        btn_next_raw = 1'b1;
        step(7);
        check("deb_pulse_cyc_occ", occupancy, 0);
        step(1);
        check("deb_push_occ", occupancy, 1);
        step(4);
        btn_next_raw = 1'b0;
        step(10);
        check("deb_release_occ", occupancy, 1);
        check("deb_data", sym_if.sym_data, 4'hC);
        check("deb_valid", sym_if.sym_valid, 1);
        sym_if.sym_ready = 1'b1;
        step(1);
        sym_if.sym_ready = 1'b0;
        check("deb_pop_valid", sym_if.sym_valid, 0);

        // Capture and order
        press_next(4'h3);
        press_next(4'hA);
        press_next(4'h5);
        check("cap_occ", occupancy, 3);
        sym_if.sym_ready = 1'b1;
        check("cap_d0", sym_if.sym_data, 4'h3);
        step(1);
        check("cap_d1", sym_if.sym_data, 4'hA);
        step(1);
        check("cap_d2", sym_if.sym_data, 4'h5);
        step(1);
        check("cap_empty", sym_if.sym_valid, 0);
        sym_if.sym_ready = 1'b0;

        // Overflow
        for (int v = 1; v <= 9; v++) begin
            press_next(SYM_W'(v));
        end
        check("ovf_occ", occupancy, 8);
        check("ovf_flag", overflow, 1);
        check("ovf_head", sym_if.sym_data, 1);
        sw_in = 4'hA;
        step(3);
        btn_next_raw = 1'b1;
        step(7);
        sym_if.sym_ready = 1'b1;
        step(1);
        sym_if.sym_ready = 1'b0;
        check("full_pushpop_occ", occupancy, 8);
        check("full_pushpop_head", sym_if.sym_data, 2);
        btn_next_raw = 1'b0;
        step(8);
        sym_if.sym_ready = 1'b1;
        for (int v = 2; v <= 8; v++) begin
            check("ovf_drain", sym_if.sym_data, v);
            step(1);
        end
        check("ovf_drain_last", sym_if.sym_data, 4'hA);
        step(1);
        check("ovf_drain_empty", sym_if.sym_valid, 0);
        sym_if.sym_ready = 1'b0;
        check("ovf_sticky", overflow, 1);

        // Done with two queued symbols
        press_next(4'h6);
        press_next(4'h9);
        btn_done_raw = 1'b1;
        step(7);
        check("done_pulse_open", entry_open, 1);
        step(1);
        check("drain_open", entry_open, 0);
        btn_next_raw = 1'b1;
        step(8);
        btn_next_raw = 1'b0;
        btn_done_raw = 1'b0;
        step(8);
        check("drain_ignore_occ", occupancy, 2);
        check("drain_still", entry_open, 0);
        sym_if.sym_ready = 1'b1;
        check("drain_d0", sym_if.sym_data, 4'h6);
        step(1);
        check("drain_d1", sym_if.sym_data, 4'h9);
        check("drain_no_end", end_pulse, 0);
        step(1);
        sym_if.sym_ready = 1'b0;
        check("drain_end", end_pulse, 1);
        check("drain_end_valid", sym_if.sym_valid, 0);
        step(1);
        check("drain_end_gone", end_pulse, 0);
        check("drain_reopen", entry_open, 1);

        // Simultaneous Next and Done
        sw_in = 4'h7;
        step(3);
        btn_next_raw = 1'b1;
        btn_done_raw = 1'b1;
        step(8);
        btn_next_raw = 1'b0;
        btn_done_raw = 1'b0;
        check("both_occ", occupancy, 1);
        check("both_open", entry_open, 0);
        check("both_data", sym_if.sym_data, 4'h7);
        sym_if.sym_ready = 1'b1;
        step(1);
        sym_if.sym_ready = 1'b0;
        check("both_end", end_pulse, 1);
        check("both_end_occ", occupancy, 0);
        step(1);
        check("both_reopen", entry_open, 1);
        step(8);

        // Done with an empty FIFO
        btn_done_raw = 1'b1;
        step(8);
        check("empty_p1_end", end_pulse, 0);
        check("empty_p1_open", entry_open, 0);
        step(1);
        check("empty_p2_end", end_pulse, 1);
        step(1);
        check("empty_p3_end", end_pulse, 0);
        check("empty_p3_open", entry_open, 1);
        btn_done_raw = 1'b0;
        step(8);

        // Reset in the middle of a drain
        for (int v = 1; v <= 5; v++) begin
            press_next(SYM_W'(v));
        end
        btn_done_raw = 1'b1;
        step(8);
        btn_done_raw = 1'b0;
        check("mid_occ", occupancy, 5);
        check("mid_ovf", overflow, 1);
        check("mid_open", entry_open, 0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_valid", sym_if.sym_valid, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_open", entry_open, 1);
        check("mid_rst_data", sym_if.sym_data, 0);
        for (int i = 0; i < 20; i++) begin
            if (end_pulse) seen_end++;
            step(1);
        end
        check("mid_rst_no_end", seen_end, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
